// File: rtl/clk_div_seq_pkg.sv
// Shared types for the clock divider sequencer.
// State encoding, default widths and the table entry layout.
package clk_div_seq_pkg;

  localparam int ADDR_W_DEF  = 3;
  localparam int DWELL_W_DEF = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_DWELL,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic [31:0]            div;
    logic [DWELL_W_DEF-1:0] dwell;
  } entry_t;

endpackage

// File: rtl/clk_div_seq_table.sv
// Step table: one write port, one registered read port.
// A write to the address being read is forwarded so a same-cycle start sees new data.
module clk_div_seq_table #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 56
) (
  input  logic              inclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port plus registered read with write-through forwarding
  always_ff @(posedge inclk) begin
    if (we)
      mem[waddr] <= wdata;
    if (we && (waddr == raddr))
      rdata <= wdata;
    else
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/clk_div_sequencer.sv
// Steps the 32-bit clock divider through a programmed list of ratios.
// Each step: load ratio, hold divider in reset, then dwell.
module clk_div_sequencer
  import clk_div_seq_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DWELL_W     = DWELL_W_DEF,
  parameter int RST_CYCLES  = 2,
  parameter int DEFAULT_DIV = 2
) (
  input  logic               inclk,
  input  logic               Reset,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [31:0]        cfg_div,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [ADDR_W-1:0]  cfg_last,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  output logic [31:0]        div_clk_count,
  output logic               div_reset,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  step_idx
);

  localparam int DATA_W = 32 + DWELL_W;
  localparam int RC_W   = $clog2(RST_CYCLES + 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   idx_q, idx_nxt;
  logic [ADDR_W-1:0]   last_q;
  logic [31:0]         div_q;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic [RC_W-1:0]     rst_cnt;
  logic [DATA_W-1:0]   rd_data;
  logic [31:0]         rd_div;
  logic [DWELL_W-1:0]  rd_dwell;
  logic                accept;

  assign rd_div   = rd_data[DATA_W-1:DWELL_W];
  assign rd_dwell = rd_data[DWELL_W-1:0];
  assign accept   = (state == S_IDLE) && start && !stop;

  assign busy = (state == S_LOAD) || (state == S_HOLD)
             || (state == S_DWELL);
  assign done          = (state == S_FINISH);
  assign div_reset     = (state != S_DWELL);
  assign div_clk_count = div_q;
  assign step_idx      = idx_q;

  // Table is read at the next step index so data is ready during LOAD
  clk_div_seq_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_table (
    .inclk (inclk),
    .we    (cfg_we && !busy),
    .waddr (cfg_addr),
    .wdata ({cfg_div, cfg_dwell}),
    .raddr (idx_nxt),
    .rdata (rd_data)
  );

  // Next-state and next step index
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_LOAD;
          idx_nxt   = '0;
        end
      end
      S_LOAD: begin
        state_nxt = stop ? S_FINISH : S_HOLD;
      end
      S_HOLD: begin
        if (stop)
          state_nxt = S_FINISH;
        else if (rst_cnt == RC_W'(1))
          state_nxt = S_DWELL;
      end
      S_DWELL: begin
        if (stop) begin
          state_nxt = S_FINISH;
        end else if (dwell_cnt == DWELL_W'(1)) begin
          if (idx_q == last_q) begin
            if (loop_en) begin
              state_nxt = S_LOAD;
              idx_nxt   = '0;
            end else begin
              state_nxt = S_FINISH;
            end
          end else begin
            state_nxt = S_LOAD;
            idx_nxt   = idx_q + 1'b1;
          end
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, index and latched last-step registers
  always_ff @(posedge inclk) begin
    if (Reset) begin
      state  <= S_IDLE;
      idx_q  <= '0;
      last_q <= '0;
    end else begin
      state <= state_nxt;
      idx_q <= idx_nxt;
      if (accept)
        last_q <= cfg_last;
    end
  end

  // Divide ratio register and the hold/dwell down-counters
  always_ff @(posedge inclk) begin
    if (Reset) begin
      div_q     <= 32'(DEFAULT_DIV);
      dwell_cnt <= '0;
      rst_cnt   <= '0;
    end else begin
      if (state == S_LOAD && !stop) begin
        div_q     <= rd_div;
        dwell_cnt <= (rd_dwell == '0) ? DWELL_W'(1) : rd_dwell;
        rst_cnt   <= RC_W'(RST_CYCLES);
      end
      if (state == S_HOLD)
        rst_cnt <= rst_cnt - 1'b1;
      if (state == S_DWELL)
        dwell_cnt <= dwell_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Scoreboard bench for clk_div_sequencer.
// Expected per-cycle outputs are queued; a monitor compares on busy/done cycles.
module tb_clk_div_sequencer;

  logic        inclk;
  logic        Reset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_div;
  logic [23:0] cfg_dwell;
  logic [2:0]  cfg_last;
  logic        loop_en;
  logic        start;
  logic        stop;
  logic [31:0] div_clk_count;
  logic        div_reset;
  logic        busy;
  logic        done;
  logic [2:0]  step_idx;

  typedef struct packed {
    logic [31:0] div;
    logic        rst;
    logic        bsy;
    logic        dn;
    logic [2:0]  idx;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  clk_div_sequencer dut (
    .inclk         (inclk),
    .Reset         (Reset),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_div       (cfg_div),
    .cfg_dwell     (cfg_dwell),
    .cfg_last      (cfg_last),
    .loop_en       (loop_en),
    .start         (start),
    .stop          (stop),
    .div_clk_count (div_clk_count),
    .div_reset     (div_reset),
    .busy          (busy),
    .done          (done),
    .step_idx      (step_idx)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;
  always @(posedge inclk) cyc <= cyc + 1;

  // Monitor: every busy or done cycle consumes one expected entry
  always @(negedge inclk) begin
    obs_t got;
    obs_t e;
    if (busy === 1'b1 || done === 1'b1) begin
      got = '{div_clk_count, div_reset, busy, done, step_idx};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL trace_extra cyc=%0d got=%h nothing expected",
                 cyc, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL trace cyc=%0d got div=%0d rst=%b busy=%b done=%b idx=%0d want div=%0d rst=%b busy=%b done=%b idx=%0d",
                   cyc, got.div, got.rst, got.bsy, got.dn, got.idx,
                   e.div, e.rst, e.bsy, e.dn, e.idx);
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push_step(int prev, int div, int dw, int idx);
    exp_q.push_back('{32'(prev), 1'b1, 1'b1, 1'b0, 3'(idx)});
    repeat (2) exp_q.push_back('{32'(div), 1'b1, 1'b1, 1'b0, 3'(idx)});
    repeat (dw) exp_q.push_back('{32'(div), 1'b0, 1'b1, 1'b0, 3'(idx)});
  endtask

  task automatic push_fin(int div, int idx);
    exp_q.push_back('{32'(div), 1'b1, 1'b0, 1'b1, 3'(idx)});
  endtask

  task automatic write_entry(int a, int d, int w);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(a);
    cfg_div   = 32'(d);
    cfg_dwell = 24'(w);
    @(posedge inclk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_start(int last, logic lp);
    cfg_last = 3'(last);
    loop_en  = lp;
    start    = 1'b1;
    @(posedge inclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge inclk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=busy want=idle", name);
    end
    repeat (2) @(posedge inclk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_div = '0;
    cfg_dwell = '0; cfg_last = '0; loop_en = 1'b0;
    start = 1'b0; stop = 1'b0;
    repeat (3) @(posedge inclk);
    #1;
    check("rst_div_reset", 32'(div_reset), 1);
    check("rst_count", div_clk_count, 2);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_idx", 32'(step_idx), 0);
    Reset = 1'b0;

    write_entry(0, 4, 5);
    write_entry(1, 8, 3);

    push_step(2, 4, 5, 0);
    push_step(4, 8, 3, 1);
    push_fin(8, 1);
    do_start(1, 1'b0);
    wait_idle("oneshot", 100);
    check("oneshot_idle_busy", 32'(busy), 0);
    check("oneshot_idle_done", 32'(done), 0);
    check("oneshot_keep_div", div_clk_count, 8);

    push_step(8, 4, 5, 0);
    push_step(4, 8, 3, 1);
    exp_q.push_back('{32'd8, 1'b1, 1'b1, 1'b0, 3'd0});
    repeat (2) exp_q.push_back('{32'd4, 1'b1, 1'b1, 1'b0, 3'd0});
    repeat (2) exp_q.push_back('{32'd4, 1'b0, 1'b1, 1'b0, 3'd0});
    push_fin(4, 0);
    do_start(1, 1'b1);
    repeat (18) @(posedge inclk);
    #1;
    stop = 1'b1;
    @(posedge inclk); #1;
    stop = 1'b0;
    check("stop_done", 32'(done), 1);
    @(posedge inclk); #1;
    check("stop_idle_busy", 32'(busy), 0);
    check("stop_idle_done", 32'(done), 0);

    push_step(4, 6, 1, 0);
    push_fin(6, 0);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_div = 32'd6; cfg_dwell = 24'd0;
    cfg_last = 3'd0; loop_en = 1'b0; start = 1'b1;
    @(posedge inclk); #1;
    cfg_we = 1'b0; start = 1'b0;
    wait_idle("dwell0", 50);

    start = 1'b1; stop = 1'b1;
    @(posedge inclk); #1;
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 0);
    @(posedge inclk); #1;
    check("startstop_busy2", 32'(busy), 0);
    check("startstop_done", 32'(done), 0);

    push_step(6, 6, 1, 0);
    push_fin(6, 0);
    do_start(0, 1'b0);
    write_entry(0, 99, 7);
    wait_idle("busy_write", 50);

    push_step(6, 6, 1, 0);
    push_fin(6, 0);
    do_start(0, 1'b0);
    wait_idle("replay", 50);
    check("replay_div", div_clk_count, 6);

    exp_q.push_back('{32'd6, 1'b1, 1'b1, 1'b0, 3'd0});
    exp_q.push_back('{32'd6, 1'b1, 1'b1, 1'b0, 3'd0});
    do_start(0, 1'b0);
    @(posedge inclk); #1;
    Reset = 1'b1;
    @(posedge inclk); #1;
    check("midrst_count", div_clk_count, 2);
    check("midrst_div_reset", 32'(div_reset), 1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_idx", 32'(step_idx), 0);
    Reset = 1'b0;
    repeat (2) @(posedge inclk);
    #1;

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
